chess_move_controller: RTL and testbench

Sequencing FSM between the player buttons/cursor and the board store. It turns `select`/`place` presses into legal, turn-checked moves. Each move reads the source and destination squares, gets the legal-move mask from the move generator over a request/valid handshake, then performs two board writes (destination, then source). It also tracks side-to-move, pawn promotion and king capture. It sits between `positionCounter` (cursor) and the board storage and move-generator datapath.

---
 rtl/chess_pkg.sv | 31 +++
 rtl/chess_move_controller_button_edge.sv | 37 +++
 rtl/chess_move_controller.sv | 216 +++++++++++++++++++++
 tb/tb_chess_move_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared piece encoding, FSM state type and board helpers for the chess move controller.
package chess_pkg;

  typedef struct packed {
    logic [2:0] ptype;
    logic       colour;
    logic       occ;
  } piece_t;

  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam piece_t EMPTY = 5'b00000;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SRC, S_CHK_SRC, S_GEN_WAIT, S_ARMED,
    S_RD_DST, S_CHK_DST, S_WR_DST, S_WR_SRC, S_OVER
  } state_e;

  function automatic logic [5:0] sq_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/chess_move_controller_button_edge.sv
// Raw button synchronizer with a registered one-cycle rising-edge pulse.
module button_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = btn;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/chess_move_controller.sv
// Move sequencer: select/place presses -> turn check, generator handshake, two board writes.
module chess_move_controller
  import chess_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GEN_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic        place,
  input  logic [2:0]  rowNum,
  input  logic [2:0]  columnNum,
  output logic [5:0]  rd_addr,
  input  logic [4:0]  rd_data,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [4:0]  wr_data,
  output logic        gen_req,
  output logic [2:0]  gen_row,
  output logic [2:0]  gen_col,
  input  logic        gen_valid,
  input  logic [63:0] gen_mask,
  output logic        turn,
  output logic        sel_valid,
  output logic [2:0]  sel_row,
  output logic [2:0]  sel_col,
  output logic [63:0] move_mask,
  output logic        err,
  output logic        game_over,
  output logic        winner
);

  localparam int unsigned TW = $clog2(GEN_TIMEOUT + 1);

  logic sel_p, plc_p;

  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sel_edge (
    .clk(clk), .reset(reset), .btn(select), .pulse(sel_p)
  );
  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_plc_edge (
    .clk(clk), .reset(reset), .btn(place), .pulse(plc_p)
  );

  state_e        state_q, state_d;
  logic [5:0]    src_q, src_d, dst_q, dst_d, rd_addr_q, rd_addr_d;
  piece_t        piece_q, piece_d;
  logic [63:0]   mask_q, mask_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          sel_valid_q, sel_valid_d, turn_q, turn_d;
  logic          capture_q, capture_d, game_over_q, game_over_d;
  logic          winner_q, winner_d, err_q, err_d, gen_req_q, gen_req_d;
  piece_t        rd_piece, wr_piece;
  logic          promote;

  assign rd_piece = piece_t'(rd_data);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rd_addr_d   = rd_addr_q;
    piece_d     = piece_q;
    mask_d      = mask_q;
    tmo_d       = tmo_q;
    sel_valid_d = sel_valid_q;
    turn_d      = turn_q;
    capture_d   = capture_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    err_d       = 1'b0;
    gen_req_d   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    // A pawn reaching the far rank for its colour is written back as a queen.
    promote  = (piece_q.ptype == PAWN) &&
               (((piece_q.colour == WHITE) && (dst_q[5:3] == 3'd0)) ||
                ((piece_q.colour == BLACK) && (dst_q[5:3] == 3'd7)));
    wr_piece = piece_q;
    if (promote) wr_piece.ptype = QUEEN;
    wr_data = '0;

    case (state_q)
      S_IDLE: begin
        if (sel_p) begin
          src_d     = sq_idx(rowNum, columnNum);
          rd_addr_d = sq_idx(rowNum, columnNum);
          state_d   = S_RD_SRC;
        end else if (plc_p) begin
          err_d = 1'b1;
        end
      end
      S_RD_SRC: state_d = S_CHK_SRC;
      S_CHK_SRC: begin
        if (rd_piece.occ && (rd_piece.colour == turn_q)) begin
          piece_d   = rd_piece;
          gen_req_d = 1'b1;
          tmo_d     = '0;
          capture_d = 1'b0;
          state_d   = S_GEN_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GEN_WAIT: begin
        if (gen_valid) begin
          if (gen_mask == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            mask_d      = gen_mask;
            sel_valid_d = 1'b1;
            state_d     = S_ARMED;
          end
        end else if (tmo_q == TW'(GEN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_ARMED: begin
        if (plc_p) begin
          dst_d = sq_idx(rowNum, columnNum);
          if (mask_q[sq_idx(rowNum, columnNum)]) begin
            rd_addr_d = sq_idx(rowNum, columnNum);
            state_d   = S_RD_DST;
          end else begin
            err_d = 1'b1;
          end
        end else if (sel_p) begin
          mask_d      = '0;
          sel_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_RD_DST: state_d = S_CHK_DST;
      S_CHK_DST: begin
        if (rd_piece.occ && (rd_piece.ptype == KING)) capture_d = 1'b1;
        state_d = S_WR_DST;
      end
      S_WR_DST: begin
        wr_en   = 1'b1;
        wr_addr = dst_q;
        wr_data = wr_piece;
        state_d = S_WR_SRC;
      end
      S_WR_SRC: begin
        wr_en       = 1'b1;
        wr_addr     = src_q;
        wr_data     = EMPTY;
        turn_d      = ~turn_q;
        sel_valid_d = 1'b0;
        mask_d      = '0;
        if (capture_q) begin
          game_over_d = 1'b1;
          winner_d    = turn_q;
          state_d     = S_OVER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OVER: state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rd_addr_q   <= '0;
      piece_q     <= EMPTY;
      mask_q      <= '0;
      tmo_q       <= '0;
      sel_valid_q <= 1'b0;
      turn_q      <= WHITE;
      capture_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      err_q       <= 1'b0;
      gen_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rd_addr_q   <= rd_addr_d;
      piece_q     <= piece_d;
      mask_q      <= mask_d;
      tmo_q       <= tmo_d;
      sel_valid_q <= sel_valid_d;
      turn_q      <= turn_d;
      capture_q   <= capture_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      err_q       <= err_d;
      gen_req_q   <= gen_req_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign gen_req   = gen_req_q;
  assign gen_row   = src_q[5:3];
  assign gen_col   = src_q[2:0];
  assign turn      = turn_q;
  assign sel_valid = sel_valid_q;
  assign sel_row   = src_q[5:3];
  assign sel_col   = src_q[2:0];
  assign move_mask = mask_q;
  assign err       = err_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_chess_move_controller.sv
// Scoreboard bench: board/generator models, expected writes queued at place and popped on wr_en.
module tb_chess_move_controller;
  import chess_pkg::*;

  logic        clk = 1'b0, reset = 1'b0, select = 1'b0, place = 1'b0;
  logic [2:0]  rowNum = '0, columnNum = '0;
  logic [5:0]  rd_addr, wr_addr;
  logic [4:0]  rd_data, wr_data;
  logic        wr_en, gen_req, gen_valid = 1'b0;
  logic [2:0]  gen_row, gen_col, sel_row, sel_col;
  logic [63:0] gen_mask = '0, move_mask;
  logic        turn, sel_valid, err, game_over, winner;

  always #5 clk = ~clk;

  chess_move_controller #(.SYNC_STAGES(2), .GEN_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .select(select), .place(place),
    .rowNum(rowNum), .columnNum(columnNum),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .gen_req(gen_req), .gen_row(gen_row), .gen_col(gen_col),
    .gen_valid(gen_valid), .gen_mask(gen_mask),
    .turn(turn), .sel_valid(sel_valid), .sel_row(sel_row), .sel_col(sel_col),
    .move_mask(move_mask), .err(err), .game_over(game_over), .winner(winner)
  );

  typedef struct packed { logic [5:0] a; logic [4:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t exp_e;

  logic [4:0]  board [64];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, t_press = 0, req_cyc = 0, wr_cyc = 0;
  int          wr_cnt = 0, err_cnt = 0, req_cnt = 0, wr_run = 0;
  logic        err_prev = 1'b0, req_prev = 1'b0, wr_prev = 1'b0;
  logic        gen_hold = 1'b0;
  logic [63:0] gen_mask_cfg = '0;
  logic [5:0]  exp_src = '0;
  int          gen_cd = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rd_data <= board[rd_addr];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Board store and protocol monitor.
  initial begin
    for (int i = 0; i < 64; i++) board[i] = EMPTY;
    board[52] = 5'b00101;
    board[8]  = 5'b00111;
    board[11] = 5'b00101;
    board[4]  = 5'b11011;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        wr_cnt++;
        wr_run++;
        if (!wr_prev) wr_cyc = cyc;
        check("wr_run_le2", 64'(wr_run <= 2), 1);
        check("wr_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("wr_addr", wr_addr, exp_e.a);
          check("wr_data", wr_data, exp_e.d);
        end
        board[wr_addr] = wr_data;
      end else begin
        wr_run = 0;
      end
      if (err) begin
        err_cnt++;
        check("err_width", err_prev, 0);
      end
      if (gen_req) begin
        req_cnt++;
        req_cyc = cyc;
        check("req_width", req_prev, 0);
        check("req_src", {gen_row, gen_col}, exp_src);
      end
      wr_prev  = wr_en;
      err_prev = err;
      req_prev = gen_req;
    end
  end

  // Move generator: answers each request two cycles later unless held off.
  initial forever begin
    @(negedge clk);
    if (gen_valid) gen_valid = 1'b0;
    if (gen_cd > 0) begin
      gen_cd--;
      if (gen_cd == 0) begin
        gen_valid = 1'b1;
        gen_mask  = gen_mask_cfg;
      end
    end
    if (gen_req && !gen_hold) gen_cd = 2;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic is_plc, input logic [2:0] r, input logic [2:0] c);
    rowNum    = r;
    columnNum = c;
    t_press   = cyc;
    if (is_plc) place = 1'b1; else select = 1'b1;
    idle(5);
    select = 1'b0;
    place  = 1'b0;
    idle(4);
  endtask

  task automatic do_select(input logic [2:0] r, input logic [2:0] c, input logic [63:0] m);
    gen_mask_cfg = m;
    exp_src      = {r, c};
    press(1'b0, r, c);
    idle(4);
  endtask

  task automatic expect_wr(input logic [5:0] a, input logic [4:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  int  e0, r0, w0;
  logic seen;

  initial begin
    idle(3);
    check("rst_turn", turn, 0);
    check("rst_sel_valid", sel_valid, 0);
    check("rst_move_mask", move_mask, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_err", err, 0);
    check("rst_gen_req", gen_req, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    reset = 1'b1;
    idle(2);

    e0 = err_cnt; r0 = req_cnt;
    do_select(3'd1, 3'd0, 64'd1 << 16);
    check("wrong_colour_err", err_cnt - e0, 1);
    check("wrong_colour_noreq", req_cnt - r0, 0);
    check("wrong_colour_armed", sel_valid, 0);

    e0 = err_cnt;
    press(1'b1, 3'd4, 3'd4);
    check("idle_place_err", err_cnt - e0, 1);

    r0 = req_cnt;
    do_select(3'd6, 3'd4, 64'd1 << 36);
    check("t1_req_once", req_cnt - r0, 1);
    check("sel_to_req_lat", req_cyc - t_press, 6);
    check("t1_sel_valid", sel_valid, 1);
    check("t1_sel_sq", {sel_row, sel_col}, {3'd6, 3'd4});
    check("t1_move_mask", move_mask, 64'd1 << 36);
    expect_wr(6'd36, 5'b00101);
    expect_wr(6'd52, 5'b00000);
    w0 = wr_cnt;
    press(1'b1, 3'd4, 3'd4);
    idle(4);
    check("plc_to_wr_lat", wr_cyc - t_press, 6);
    check("t1_wr_count", wr_cnt - w0, 2);
    check("t1_exp_drained", exp_q.size(), 0);
    check("t1_turn", turn, 1);
    check("t1_sel_cleared", sel_valid, 0);
    check("t1_mask_cleared", move_mask, 0);

    do_select(3'd1, 3'd0, 64'd1 << 16);
    expect_wr(6'd16, 5'b00111);
    expect_wr(6'd8, 5'b00000);
    press(1'b1, 3'd2, 3'd0);
    idle(4);
    check("blk1_turn", turn, 0);

    do_select(3'd1, 3'd3, 64'd1 << 3);
    e0 = err_cnt; w0 = wr_cnt;
    press(1'b1, 3'd0, 3'd2);
    check("bad_dst_err", err_cnt - e0, 1);
    check("bad_dst_armed", sel_valid, 1);
    check("bad_dst_nowr", wr_cnt - w0, 0);
    check("bad_dst_mask", move_mask, 64'd1 << 3);
    expect_wr(6'd3, 5'b10101);
    expect_wr(6'd11, 5'b00000);
    press(1'b1, 3'd0, 3'd3);
    idle(4);
    check("promo_wr_count", wr_cnt - w0, 2);
    check("promo_turn", turn, 1);

    do_select(3'd2, 3'd0, 64'd1 << 24);
    check("cancel_armed", sel_valid, 1);
    e0 = err_cnt;
    press(1'b0, 3'd2, 3'd0);
    check("cancel_sel_valid", sel_valid, 0);
    check("cancel_mask", move_mask, 0);
    check("cancel_no_err", err_cnt - e0, 0);

    e0 = err_cnt;
    do_select(3'd2, 3'd0, 64'd0);
    check("zero_mask_err", err_cnt - e0, 1);
    check("zero_mask_idle", sel_valid, 0);

    do_select(3'd2, 3'd0, 64'd1 << 24);
    expect_wr(6'd24, 5'b00111);
    expect_wr(6'd16, 5'b00000);
    press(1'b1, 3'd3, 3'd0);
    idle(4);
    check("blk2_turn", turn, 0);

    do_select(3'd0, 3'd3, 64'd1 << 4);
    expect_wr(6'd4, 5'b10101);
    expect_wr(6'd3, 5'b00000);
    press(1'b1, 3'd0, 3'd4);
    idle(4);
    check("cap_game_over", game_over, 1);
    check("cap_winner", winner, 0);
    check("cap_turn", turn, 1);

    e0 = err_cnt; r0 = req_cnt; w0 = wr_cnt;
    do_select(3'd4, 3'd4, 64'd1 << 28);
    press(1'b1, 3'd3, 3'd4);
    idle(4);
    check("over_no_req", req_cnt - r0, 0);
    check("over_no_wr", wr_cnt - w0, 0);
    check("over_no_err", err_cnt - e0, 0);
    check("over_sticky", game_over, 1);

    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
    check("rst2_game_over", game_over, 0);
    check("rst2_turn", turn, 0);

    do_select(3'd4, 3'd4, 64'd1 << 28);
    check("rst_mid_armed", sel_valid, 1);
    expect_wr(6'd28, 5'b00101);
    w0 = wr_cnt;
    rowNum = 3'd3; columnNum = 3'd4;
    place = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle(1);
      if (wr_en) begin
        seen  = 1'b1;
        reset = 1'b0;
        place = 1'b0;
      end
    end
    place = 1'b0;
    check("rst_mid_wr_seen", seen, 1);
    idle(2);
    reset = 1'b1;
    idle(4);
    check("rst_mid_one_wr", wr_cnt - w0, 1);
    check("rst_mid_exp_drained", exp_q.size(), 0);
    check("rst_mid_turn", turn, 0);
    check("rst_mid_sel_valid", sel_valid, 0);

    gen_hold = 1'b1;
    e0 = err_cnt; r0 = req_cnt;
    do_select(3'd4, 3'd4, 64'd1 << 28);
    idle(300);
    check("tmo_req", req_cnt - r0, 1);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_sel_valid", sel_valid, 0);
    gen_hold = 1'b0;
    do_select(3'd4, 3'd4, 64'd1 << 28);
    check("tmo_idle_rearm", sel_valid, 1);
    check("tmo_idle_mask", move_mask, 64'd1 << 28);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
